// File: rtl/regbus_master.sv
// ----------------------------------------------------------------------------
// regbus_master
//
// Initiator for the simple register bus. It takes one command at a time over
// a valid/ready command channel, runs one single-cycle WRITE or READ strobe
// on the bus, and returns one response per command over a valid/ready
// response channel. READ_DATA is sampled RD_LAT cycles after the READ strobe,
// so both combinational and delayed responders are supported.
//
// Optional feature (compile-time macro REGBUS_MASTER_READBACK_EN):
//   When defined, every write is followed by a verify read at the same
//   address. The value read back is returned on RSP_DATA, and RSP_ERR flags a
//   difference from the data written. When undefined, write responses carry
//   RSP_DATA=0 and RSP_ERR=0.
//
// Parameters:
//   ADDR_W  bus address width
//   DATA_W  bus data width
//   RD_LAT  extra cycles between READ strobe and READ_DATA sampling (0..7)
//
// Ports:
//   CLK, RST_N            clock (rising edge), asynchronous active-low reset
//   CMD_VALID/CMD_READY   command handshake
//   CMD_WR/ADDR/DATA      command: 1=write/0=read, address, write data
//   RSP_VALID/RSP_READY   response handshake
//   RSP_DATA, RSP_ERR     read data (or readback value), readback mismatch
//   WRITE, READ           bus strobes, one cycle each
//   ADDR, WRITE_DATA      bus address and write data, held between commands
//   READ_DATA             bus read data from the responder
//   BUSY                  high whenever the master is not idle
// ----------------------------------------------------------------------------
module regbus_master #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 2,
    parameter int RD_LAT = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WR,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_DATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic              RSP_ERR,
    output logic              WRITE,
    output logic              READ,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] WRITE_DATA,
    input  logic [DATA_W-1:0] READ_DATA,
    output logic              BUSY
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR      = 3'd1;
    localparam logic [2:0] ST_RD      = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;
`ifdef REGBUS_MASTER_READBACK_EN
    localparam logic [2:0] ST_VRD      = 3'd5;
    localparam logic [2:0] ST_VRD_WAIT = 3'd6;
`endif

    // Counter value during the last wait cycle; sampling happens on the edge
    // that ends that cycle. Only meaningful when RD_LAT is non-zero.
    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    logic [2:0]        state;
    logic [2:0]        lat_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;

    // Main controller: latches the command, sequences the bus strobes,
    // counts read latency, captures READ_DATA and holds the response until
    // the consumer takes it. Reset drops any in-flight command silently.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            lat_cnt     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (CMD_VALID) begin
                        addr_q  <= CMD_ADDR;
                        wdata_q <= CMD_DATA;
                        lat_cnt <= '0;
                        state   <= CMD_WR ? ST_WR : ST_RD;
                    end
                end
                ST_WR: begin
`ifdef REGBUS_MASTER_READBACK_EN
                    lat_cnt <= '0;
                    state   <= ST_VRD;
`else
                    rsp_data_q  <= '0;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state       <= ST_RESP;
`endif
                end
                ST_RD: begin
                    if (RD_LAT == 0) begin
                        rsp_data_q  <= READ_DATA;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    lat_cnt <= lat_cnt + 3'd1;
                    if (lat_cnt == LAT_LAST) begin
                        rsp_data_q  <= READ_DATA;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
`ifdef REGBUS_MASTER_READBACK_EN
                // Verify read: same sampling rule as a normal read, but the
                // sampled value is also compared against the data written.
                ST_VRD: begin
                    if (RD_LAT == 0) begin
                        rsp_data_q  <= READ_DATA;
                        rsp_err_q   <= (READ_DATA != wdata_q);
                        rsp_valid_q <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        state <= ST_VRD_WAIT;
                    end
                end
                ST_VRD_WAIT: begin
                    lat_cnt <= lat_cnt + 3'd1;
                    if (lat_cnt == LAT_LAST) begin
                        rsp_data_q  <= READ_DATA;
                        rsp_err_q   <= (READ_DATA != wdata_q);
                        rsp_valid_q <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
`endif
                ST_RESP: begin
                    if (RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes and handshake readiness are decoded from the state register
    // only, so CMD_READY never depends combinationally on CMD_VALID and the
    // two strobes can never be high together.
    assign CMD_READY  = (state == ST_IDLE);
    assign BUSY       = (state != ST_IDLE);
    assign WRITE      = (state == ST_WR);
`ifdef REGBUS_MASTER_READBACK_EN
    assign READ       = (state == ST_RD) || (state == ST_VRD);
`else
    assign READ       = (state == ST_RD);
`endif
    assign ADDR       = addr_q;
    assign WRITE_DATA = wdata_q;
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_DATA   = rsp_data_q;
    assign RSP_ERR    = rsp_err_q;

endmodule

// File: tb/tb_regbus_master.sv
// ----------------------------------------------------------------------------
// tb_regbus_master
//
// Two masters share one clock: instance 0 with RD_LAT=0 and instance 1 with
// RD_LAT=2. Each drives its own register-map responder (8 entries, address 1
// is a 1-bit register). Expected responses and timing come from a shadow
// register map and the transaction-level latency rules.
// ----------------------------------------------------------------------------
module tb_regbus_master;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 2;

    logic clk;

    logic              rst_n      [2];
    logic              cmd_valid  [2];
    logic              cmd_ready  [2];
    logic              cmd_wr     [2];
    logic [ADDR_W-1:0] cmd_addr   [2];
    logic [DATA_W-1:0] cmd_data   [2];
    logic              rsp_valid  [2];
    logic              rsp_ready  [2];
    logic [DATA_W-1:0] rsp_data   [2];
    logic              rsp_err    [2];
    logic              write      [2];
    logic              read       [2];
    logic [ADDR_W-1:0] addr       [2];
    logic [DATA_W-1:0] write_data [2];
    logic [DATA_W-1:0] read_data  [2];
    logic              busy       [2];

    // Responder storage and the bench's own shadow copy of it.
    logic [DATA_W-1:0] mem     [2][8];
    logic [DATA_W-1:0] exp_mem [2][8];

    // Read-data override, used to present a value that changes mid-read.
    logic              ovr_en  [2];
    logic [DATA_W-1:0] ovr_val [2];
    bit                chg_en;
    logic [DATA_W-1:0] chg_val;

    int num_checks;
    int num_fails;

    regbus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(0)) u_dut0 (
        .CLK(clk), .RST_N(rst_n[0]),
        .CMD_VALID(cmd_valid[0]), .CMD_READY(cmd_ready[0]),
        .CMD_WR(cmd_wr[0]), .CMD_ADDR(cmd_addr[0]), .CMD_DATA(cmd_data[0]),
        .RSP_VALID(rsp_valid[0]), .RSP_READY(rsp_ready[0]),
        .RSP_DATA(rsp_data[0]), .RSP_ERR(rsp_err[0]),
        .WRITE(write[0]), .READ(read[0]), .ADDR(addr[0]),
        .WRITE_DATA(write_data[0]), .READ_DATA(read_data[0]), .BUSY(busy[0])
    );

    regbus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2)) u_dut1 (
        .CLK(clk), .RST_N(rst_n[1]),
        .CMD_VALID(cmd_valid[1]), .CMD_READY(cmd_ready[1]),
        .CMD_WR(cmd_wr[1]), .CMD_ADDR(cmd_addr[1]), .CMD_DATA(cmd_data[1]),
        .RSP_VALID(rsp_valid[1]), .RSP_READY(rsp_ready[1]),
        .RSP_DATA(rsp_data[1]), .RSP_ERR(rsp_err[1]),
        .WRITE(write[1]), .READ(read[1]), .ADDR(addr[1]),
        .WRITE_DATA(write_data[1]), .READ_DATA(read_data[1]), .BUSY(busy[1])
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder register write port; address 1 only keeps bit 0.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (write[i])
                mem[i][addr[i]] <= (addr[i] == 3'd1) ? {1'b0, write_data[i][0]} : write_data[i];
        end
    end

    // Combinational responder read port, optionally overridden.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            read_data[i] = ovr_en[i] ? ovr_val[i] : mem[i][addr[i]];
        end
    end

    function automatic int lat_of(input int idx);
        return (idx == 0) ? 0 : 2;
    endfunction

    function automatic logic [DATA_W-1:0] stored_value(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        return (a == 3'd1) ? {1'b0, d[0]} : d;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one command on master idx and checks strobes, latency, response
    // contents, stall behaviour and the return to idle. With keep set,
    // CMD_VALID stays high so the same command is re-offered after the
    // handshake and must be accepted on the very next edge.
    task automatic applyStimulus(input int idx, input bit wr, input logic [ADDR_W-1:0] a,
                                 input logic [DATA_W-1:0] d, input int stall, input bit keep);
        int lat, k, wr_cnt, rd_cnt, exp_cycle, exp_rd, t;
        logic [DATA_W-1:0] exp_data;
        logic exp_err;
        bit got_valid;

        lat = lat_of(idx);
        if (wr) begin
`ifdef REGBUS_MASTER_READBACK_EN
            exp_cycle = 3 + lat;
            exp_rd    = 1;
            exp_data  = stored_value(a, d);
            exp_err   = (stored_value(a, d) != d);
`else
            exp_cycle = 2;
            exp_rd    = 0;
            exp_data  = '0;
            exp_err   = 1'b0;
`endif
        end else begin
            exp_cycle = 2 + lat;
            exp_rd    = 1;
            exp_err   = 1'b0;
            if (ovr_en[idx])
                exp_data = (chg_en && lat >= 1) ? chg_val : ovr_val[idx];
            else
                exp_data = exp_mem[idx][a];
        end

        @(negedge clk);
        cmd_valid[idx] = 1'b1;
        cmd_wr[idx]    = wr;
        cmd_addr[idx]  = a;
        cmd_data[idx]  = d;
        rsp_ready[idx] = (stall == 0);
        checkOutput("cmd_ready_idle", 32'(cmd_ready[idx]), 1);
        @(posedge clk);
        #1;
        if (!keep) cmd_valid[idx] = 1'b0;

        k = 0; wr_cnt = 0; rd_cnt = 0; got_valid = 0;
        while (!got_valid && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 2 && chg_en) ovr_val[idx] = chg_val;
            checkOutput("strobe_excl", 32'(write[idx] & read[idx]), 0);
            if (write[idx]) begin
                wr_cnt++;
                checkOutput("wr_cycle", k, 1);
                checkOutput("wr_addr", 32'(addr[idx]), 32'(a));
                checkOutput("wr_data", 32'(write_data[idx]), 32'(d));
            end
            if (read[idx]) begin
                rd_cnt++;
                checkOutput("rd_cycle", k, wr ? 2 : 1);
                checkOutput("rd_addr", 32'(addr[idx]), 32'(a));
            end
            if (rsp_valid[idx]) got_valid = 1;
        end
        checkOutput("rsp_cycle", k, exp_cycle);
        if (!got_valid) return;
        checkOutput("wr_count", wr_cnt, wr ? 1 : 0);
        checkOutput("rd_count", rd_cnt, exp_rd);
        checkOutput("rsp_data", 32'(rsp_data[idx]), 32'(exp_data));
        checkOutput("rsp_err", 32'(rsp_err[idx]), 32'(exp_err));
        checkOutput("busy_resp", 32'(busy[idx]), 1);
        checkOutput("cmd_ready_resp", 32'(cmd_ready[idx]), 0);

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checkOutput("stall_valid", 32'(rsp_valid[idx]), 1);
            checkOutput("stall_data", 32'(rsp_data[idx]), 32'(exp_data));
            checkOutput("stall_err", 32'(rsp_err[idx]), 32'(exp_err));
            checkOutput("stall_cmd_ready", 32'(cmd_ready[idx]), 0);
            checkOutput("stall_strobes", 32'(write[idx] | read[idx]), 0);
        end
        rsp_ready[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("cmd_ready_after", 32'(cmd_ready[idx]), 1);
        checkOutput("rsp_valid_after", 32'(rsp_valid[idx]), 0);
        if (wr) exp_mem[idx][a] = stored_value(a, d);

        if (keep) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("reaccept_busy", 32'(busy[idx]), 1);
            checkOutput("reaccept_strobe", 32'(wr ? write[idx] : read[idx]), 1);
            cmd_valid[idx] = 1'b0;
            t = 0;
            while (!rsp_valid[idx] && t < 20) begin
                @(negedge clk);
                t++;
            end
            checkOutput("reaccept_rsp", 32'(rsp_valid[idx]), 1);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic checkResetState(input int idx, input string tag);
        checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready[idx]), 1);
        checkOutput({tag, "_busy"}, 32'(busy[idx]), 0);
        checkOutput({tag, "_write"}, 32'(write[idx]), 0);
        checkOutput({tag, "_read"}, 32'(read[idx]), 0);
        checkOutput({tag, "_addr"}, 32'(addr[idx]), 0);
        checkOutput({tag, "_wdata"}, 32'(write_data[idx]), 0);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid[idx]), 0);
        checkOutput({tag, "_rsp_data"}, 32'(rsp_data[idx]), 0);
        checkOutput({tag, "_rsp_err"}, 32'(rsp_err[idx]), 0);
    endtask

    // Test sequence: reset state, directed cases, randomized traffic, and a
    // reset in the middle of a delayed read.
    initial begin
        num_checks = 0;
        num_fails  = 0;
        chg_en     = 0;
        chg_val    = '0;
        for (int i = 0; i < 2; i++) begin
            rst_n[i]     = 1'b0;
            cmd_valid[i] = 1'b0;
            cmd_wr[i]    = 1'b0;
            cmd_addr[i]  = '0;
            cmd_data[i]  = '0;
            rsp_ready[i] = 1'b0;
            ovr_en[i]    = 1'b0;
            ovr_val[i]   = '0;
            for (int j = 0; j < 8; j++) begin
                mem[i][j]     = (j == 1) ? DATA_W'($urandom_range(0, 1)) : DATA_W'($urandom);
                exp_mem[i][j] = mem[i][j];
            end
        end
        repeat (3) @(negedge clk);
        checkResetState(0, "rst0");
        checkResetState(1, "rst1");
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);

        // Directed: write ADDR=0 data 10, read ADDR=1 with responder driving 01.
        applyStimulus(0, 1'b1, 3'd0, 2'b10, 0, 1'b0);
        ovr_en[0] = 1'b1; ovr_val[0] = 2'b01;
        applyStimulus(0, 1'b0, 3'd1, 2'b00, 0, 1'b0);
        ovr_en[0] = 1'b0;

        // Delayed read: 01 during the READ cycle, 11 from the cycle after.
        ovr_en[1] = 1'b1; ovr_val[1] = 2'b01; chg_en = 1; chg_val = 2'b11;
        applyStimulus(1, 1'b0, 3'd1, 2'b00, 0, 1'b0);
        ovr_en[1] = 1'b0; chg_en = 0;

        // Stalled response with the next command already offered.
        applyStimulus(0, 1'b1, 3'd2, 2'b01, 5, 1'b1);
        applyStimulus(1, 1'b1, 3'd4, 2'b11, 3, 1'b0);

`ifdef REGBUS_MASTER_READBACK_EN
        applyStimulus(0, 1'b1, 3'd1, 2'b11, 0, 1'b0);
        applyStimulus(0, 1'b1, 3'd0, 2'b10, 0, 1'b0);
        applyStimulus(1, 1'b1, 3'd1, 2'b11, 0, 1'b0);
`endif

        // Randomized traffic on both masters, checked against the shadow map.
        for (int n = 0; n < 40; n++) begin
            int idx, st;
            idx = n % 2;
            st  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            applyStimulus(idx, 1'($urandom), 3'($urandom), 2'($urandom), st, 1'b0);
        end

        // Reset during the wait phase of a delayed read on master 1.
        @(negedge clk);
        cmd_valid[1] = 1'b1; cmd_wr[1] = 1'b0; cmd_addr[1] = 3'd3; rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1 cmd_valid[1] = 1'b0;
        @(negedge clk);
        checkOutput("mid_rd_read", 32'(read[1]), 1);
        @(negedge clk);
        checkOutput("mid_wait_busy", 32'(busy[1]), 1);
        rst_n[1] = 1'b0;
        #1;
        checkResetState(1, "midrst");
        @(negedge clk);
        rst_n[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("post_rst_no_rsp", 32'(rsp_valid[1]), 0);
            checkOutput("post_rst_ready", 32'(cmd_ready[1]), 1);
        end

        // Master still works normally after the dropped read.
        applyStimulus(1, 1'b0, 3'd3, 2'b00, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
